// File: rtl/pll_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pll_ctrl_pkg
//   Shared definitions for the PLL reset sequencer:
//   - pll_state_e : 3-bit FSM state encoding
//   - DEF_*       : default timing constants for a 27 MHz reference clock
//   - max3()      : helper used to size the shared cycle counter
// -----------------------------------------------------------------------------
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_state_e;

  // 10 us of PLL reset at 27 MHz
  localparam int unsigned DEF_RST_HOLD_CYCLES = 270;
  // 10 ms lock window at 27 MHz
  localparam int unsigned DEF_LOCK_TIMEOUT    = 270000;
  // consecutive synchronised-lock cycles before the system is released
  localparam int unsigned DEF_LOCK_STABLE     = 1024;
  // retries after the first attempt
  localparam int unsigned DEF_MAX_RETRY       = 3;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Generic two-flop synchroniser for level signals crossing into the clk
//   domain. Used for the PLL lock input here, and intended for re-timing
//   sys_rst_o into the PLL output clock domain by downstream logic.
// Ports
//   clk  in   1      destination clock
//   rst  in   1      async active-high reset, forces q and the first stage
//                    to RST_VAL
//   d    in   WIDTH  asynchronous input
//   q    out  WIDTH  synchronised output, two clk cycles of latency
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int unsigned WIDTH   = 1,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= {WIDTH{RST_VAL}};
      q    <= {WIDTH{RST_VAL}};
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_seq.sv
// -----------------------------------------------------------------------------
// pll_rst_seq
//   Power-up / recovery sequencer for the on-chip PLL, clocked by the board
//   reference clock. Pulses the PLL reset, waits for lock with a timeout and
//   a bounded number of retries, and releases the downstream system reset once
//   lock has been stable for LOCK_STABLE cycles.
//
// Ports
//   clkin         in   1   reference clock
//   reset         in   1   async active-high reset
//   pll_lock_i    in   1   PLL lock, asynchronous to clkin
//   relock_req_i  in   1   restart the sequence and clear the retry count
//   pll_rst_o     out  1   PLL reset pin, active-high
//   sys_rst_o     out  1   downstream system reset (clkin domain), active-high
//   locked_o      out  1   high only in RUN
//   fail_o        out  1   high only in FAIL
//   retry_cnt_o   out  $clog2(MAX_RETRY+1)  retries used so far
//
// Build option
//   PLL_RELOCK_EN : when defined, loss of lock in RUN restarts the sequence
//                   with a fresh retry budget; otherwise RUN ignores lock.
//
// All outputs are registered and decoded from the next state, so they move
// on the same edge as the state register.
// -----------------------------------------------------------------------------
module pll_rst_seq
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
  parameter int unsigned LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
  parameter int unsigned LOCK_STABLE     = DEF_LOCK_STABLE,
  parameter int unsigned MAX_RETRY       = DEF_MAX_RETRY
) (
  input  logic                           clkin,
  input  logic                           reset,
  input  logic                           pll_lock_i,
  input  logic                           relock_req_i,
  output logic                           pll_rst_o,
  output logic                           sys_rst_o,
  output logic                           locked_o,
  output logic                           fail_o,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt_o
);

  localparam int unsigned CNT_MAX = max3(LOCK_TIMEOUT, RST_HOLD_CYCLES, LOCK_STABLE);
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned RW      = $clog2(MAX_RETRY + 1);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [RW-1:0] retry_t;

  localparam cnt_t   HOLD_LAST    = cnt_t'(RST_HOLD_CYCLES - 1);
  localparam cnt_t   TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK edge that first sees lock_s already counts as one stable
  // cycle, so STABLE only needs LOCK_STABLE-1 further edges (LOCK_STABLE >= 2).
  localparam cnt_t   STABLE_LAST  = cnt_t'(LOCK_STABLE - 2);
  localparam retry_t RETRY_MAX    = retry_t'(MAX_RETRY);

  pll_state_e state, state_n;
  cnt_t       cnt, cnt_n, cnt_inc;
  retry_t     retry_cnt, retry_n;
  logic       lock_s;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b0)
  ) u_lock_sync (
    .clk (clkin),
    .rst (reset),
    .d   (pll_lock_i),
    .q   (lock_s)
  );

  // Shared counter saturates at all-ones rather than wrapping.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + cnt_t'(1);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    cnt_n   = cnt_inc;
    retry_n = retry_cnt;

    case (state)
      RESET_PLL: begin
        if (cnt == HOLD_LAST) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end
      end

      WAIT_LOCK: begin
        if (lock_s) begin
          state_n = STABLE;
          cnt_n   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          cnt_n = '0;
          if (retry_cnt < RETRY_MAX) begin
            retry_n = retry_cnt + retry_t'(1);
            state_n = RESET_PLL;
          end else begin
            state_n = FAIL;
          end
        end
      end

      STABLE: begin
        if (!lock_s) begin
          // Lock glitched: go back and restart the lock timeout from zero.
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_n = RUN;
          cnt_n   = '0;
        end
      end

      RUN: begin
        cnt_n = cnt;
`ifdef PLL_RELOCK_EN
        if (!lock_s) begin
          state_n = RESET_PLL;
          cnt_n   = '0;
          retry_n = '0;
        end
`endif
      end

      FAIL: begin
        cnt_n = cnt;
      end

      default: begin
        state_n = RESET_PLL;
        cnt_n   = '0;
      end
    endcase

    // Soft relock request overrides every state; held high it pins the
    // sequence at the start of RESET_PLL.
    if (relock_req_i) begin
      state_n = RESET_PLL;
      cnt_n   = '0;
      retry_n = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State, counters and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_rst_o <= 1'b1;
      sys_rst_o <= 1'b1;
      locked_o  <= 1'b0;
      fail_o    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      retry_cnt <= retry_n;
      pll_rst_o <= (state_n == RESET_PLL) || (state_n == FAIL);
      sys_rst_o <= (state_n != RUN);
      locked_o  <= (state_n == RUN);
      fail_o    <= (state_n == FAIL);
    end
  end

  assign retry_cnt_o = retry_cnt;

endmodule
